sfu_drain: RTL

- Downstream stage of the SFU accumulator bank (8 channels x 16 output positions, 16-bit signed psums).
- Once accumulation completes, it reads the bank one output position at a time, applies ReLU per channel, and packs the 8 lanes into one 128-bit word.
- Each word is written to the output SRAM through a valid/ready write port. After the last write it pulses a bank-clear so the SFU can start the next tile.

---
 rtl/sfu_drain_pkg.sv | 30 +++
 rtl/sfu_relu_lane.sv | 39 +++
 rtl/sfu_drain.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sfu_drain_pkg.sv
// sfu_pkg: shared constants and types for the SFU accumulator-bank drain.
//   NUM_CH     lanes per output word (channels per position)
//   PSUM_W     signed partial-sum width per lane
//   NUM_POS    output positions per tile (4x4, row-major)
//   lane_t     one signed lane
//   state_t    drain controller states
//   POOL_ORDER bank read order for 2x2 max-pool (four 2x2 windows in turn)
package sfu_pkg;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned PSUM_W  = 16;
  localparam int unsigned NUM_POS = 16;

  typedef logic signed [PSUM_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    FIN
  } state_t;

  localparam logic [3:0] POOL_ORDER [NUM_POS] = '{
    4'd0,  4'd1,  4'd4,  4'd5,
    4'd2,  4'd3,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd12, 4'd13,
    4'd10, 4'd11, 4'd14, 4'd15
  };

endpackage

// File: rtl/sfu_relu_lane.sv
// sfu_relu_lane: combinational per-lane ReLU, with an optional signed
// max-compare front end used by 2x2 max-pooling.
// Build option: SFU_DRAIN_MAXPOOL_EN adds the compare ports.
// Ports:
//   din      lane read from the accumulator bank
//   cmp_in   running max so far          (SFU_DRAIN_MAXPOOL_EN only)
//   cmp_en   include cmp_in in the max   (SFU_DRAIN_MAXPOOL_EN only)
//   max_out  signed max of din / cmp_in  (SFU_DRAIN_MAXPOOL_EN only)
//   relu_out ReLU of the selected value (negative -> 0, no saturation)
module sfu_relu_lane
  import sfu_pkg::*;
(
  input  lane_t din,
`ifdef SFU_DRAIN_MAXPOOL_EN
  input  lane_t cmp_in,
  input  logic  cmp_en,
  output lane_t max_out,
`endif
  output lane_t relu_out
);

  lane_t sel;

`ifdef SFU_DRAIN_MAXPOOL_EN
  always_comb begin
    max_out = din;
    if (cmp_en && (cmp_in > din)) begin
      max_out = cmp_in;
    end
  end

  assign sel = max_out;
`else
  assign sel = din;
`endif

  assign relu_out = sel[PSUM_W-1] ? '0 : sel;

endmodule

// File: rtl/sfu_drain.sv
// sfu_drain: drains a finished SFU accumulator tile into the output SRAM.
// Reads the bank one position at a time, applies per-lane ReLU, packs
// NUM_CH lanes into one word and writes it through a valid/ready port
// behind a single output register stage, then pulses bank_clr and done.
// Build option: SFU_DRAIN_MAXPOOL_EN enables 2x2 max-pool (4 words/tile).
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        one-cycle pulse, accepted only in IDLE
//   base_addr    SRAM address of the first word, sampled on accepted start
//   rd_idx       bank position being read
//   rd_data      bank contents at rd_idx (combinational), lane i = [16i+15:16i]
//   wr_valid     write request; holds until wr_ready
//   wr_ready     SRAM accepts this cycle
//   wr_addr      write address (modulo 2^ADDR_W)
//   wr_data      ReLU'd packed word
//   bank_clr     one-cycle pulse after the last write
//   busy         high from the cycle after accepted start until done
//   done         one-cycle completion pulse
module sfu_drain
  import sfu_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic [3:0]                 rd_idx,
  input  logic [NUM_CH*PSUM_W-1:0]   rd_data,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [NUM_CH*PSUM_W-1:0]   wr_data,
  output logic                       bank_clr,
  output logic                       busy,
  output logic                       done
);

  state_t                 state;
  state_t                 state_nxt;
  logic [4:0]             pos_cnt;
  logic [ADDR_W-1:0]      base_q;
  logic [NUM_CH*PSUM_W-1:0] relu_word;
  lane_t                  relu_lane [NUM_CH];
  logic                   start_ok;
  logic                   stall;
  logic                   more;
  logic                   last_xfer;
  logic                   step;
  logic                   load;
  logic [4:0]             start_cnt;
  logic [ADDR_W-1:0]      load_addr;

  assign start_ok  = (state == IDLE) && start;
  assign stall     = wr_valid && !wr_ready;
  assign more      = (pos_cnt != 5'(NUM_POS));
  assign last_xfer = (state == DRAIN) && !more && wr_valid && wr_ready;

`ifdef SFU_DRAIN_MAXPOOL_EN
  lane_t acc     [NUM_CH];
  lane_t max_lane[NUM_CH];

  // pos_cnt counts reads; the fourth read of each window fills the stage.
  assign rd_idx    = POOL_ORDER[pos_cnt[3:0]];
  assign step      = (state == DRAIN) && more && !stall;
  assign load      = step && (pos_cnt[1:0] == 2'b11);
  assign start_cnt = '0;
  assign load_addr = base_q + ADDR_W'(pos_cnt[3:2]);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    sfu_relu_lane u_lane (
      .din      (lane_t'(rd_data[i*PSUM_W +: PSUM_W])),
      .cmp_in   (acc[i]),
      .cmp_en   (pos_cnt[1:0] != 2'b00),
      .max_out  (max_lane[i]),
      .relu_out (relu_lane[i])
    );
    assign relu_word[i*PSUM_W +: PSUM_W] = relu_lane[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else if (step) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= max_lane[i];
      end
    end
  end
`else
  // Position 0 is already on rd_data in IDLE (rd_idx rests at 0), so the
  // accepted start loads the first word directly; pos_cnt counts loads.
  assign rd_idx    = pos_cnt[3:0];
  assign step      = start_ok || ((state == DRAIN) && more && !stall);
  assign load      = step;
  assign start_cnt = 5'd1;
  assign load_addr = start_ok ? base_addr : (base_q + ADDR_W'(pos_cnt));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    sfu_relu_lane u_lane (
      .din      (lane_t'(rd_data[i*PSUM_W +: PSUM_W])),
      .relu_out (relu_lane[i])
    );
    assign relu_word[i*PSUM_W +: PSUM_W] = relu_lane[i];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bank_clr  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_xfer) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        bank_clr  = 1'b1;
        state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_cnt  <= '0;
      base_q   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= load_addr;
        wr_data  <= relu_word;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end

      if (start_ok) begin
        base_q  <= base_addr;
        pos_cnt <= start_cnt;
      end else if (step) begin
        pos_cnt <= pos_cnt + 5'd1;
      end
    end
  end

endmodule
